// File: rtl/sync_edge_multi.sv
// sync_edge_multi
//   Multi-channel conditioner for asynchronous inputs. Each channel runs an
//   N-stage synchroniser, then a glitch filter, then registered edge pulses.
//   The filter accepts a new level only after FILT_LEN consecutive samples
//   that disagree with the current level.
//   A per-channel mode selects which accepted edges produce an event pulse.
//
// Parameters
//   CH          number of independent channels (>=1)
//   SYNC_STAGES synchroniser flops per channel (>=2)
//   FILT_LEN    consecutive disagreeing samples needed to accept (>=1)
//
// Ports
//   clk        in   1     clock, all logic on posedge
//   rst        in   1     synchronous active-high reset
//   data_in    in   CH    asynchronous inputs
//   edge_mode  in   2*CH  ch i = [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
//   level_out  out  CH    filtered, synchronised level
//   pos_out    out  CH    1-cycle pulse on accepted 0->1
//   neg_out    out  CH    1-cycle pulse on accepted 1->0
//   evt_out    out  CH    pos_out/neg_out gated by edge_mode
//   evt_clr    in   CH    clear of evt_flag (SYNC_EDGE_STICKY_EN only)
//   evt_flag   out  CH    sticky event flag (SYNC_EDGE_STICKY_EN only)
//
// Build option
//   SYNC_EDGE_STICKY_EN  adds evt_clr/evt_flag. When evt_clr and a new event
//                        arrive in the same cycle, the flag is set.
module sync_edge_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   data_in,
    input  logic [2*CH-1:0] edge_mode,
    output logic [CH-1:0]   level_out,
    output logic [CH-1:0]   pos_out,
    output logic [CH-1:0]   neg_out,
    output logic [CH-1:0]   evt_out
`ifdef SYNC_EDGE_STICKY_EN
    ,
    input  logic [CH-1:0]   evt_clr,
    output logic [CH-1:0]   evt_flag
`endif
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CH-1:0] level_q, level_d;
    logic [CH-1:0] pos_q, pos_d;
    logic [CH-1:0] neg_q, neg_d;
    logic [CH-1:0] evt_q, evt_d;
    logic [CH-1:0] s_last;
    logic [CH-1:0] accept;

    always_comb begin
        sync_d  = '0;
        cnt_d   = '0;
        level_d = level_q;
        pos_d   = '0;
        neg_d   = '0;
        evt_d   = '0;
        s_last  = '0;
        accept  = '0;
        for (int i = 0; i < CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], data_in[i]};
            s_last[i] = sync_q[i][SYNC_STAGES-1];
            accept[i] = (s_last[i] != level_q[i]) && (cnt_q[i] == CW'(FILT_LEN - 1));
            // Any agreeing sample leaves cnt_d at its default of 0, restarting the count.
            if (s_last[i] != level_q[i]) begin
                if (accept[i]) begin
                    level_d[i] = s_last[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            pos_d[i] = accept[i] & s_last[i];
            neg_d[i] = accept[i] & ~s_last[i];
            evt_d[i] = (pos_d[i] & edge_mode[2*i]) | (neg_d[i] & edge_mode[2*i+1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            evt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            evt_q   <= evt_d;
        end
    end

    assign level_out = level_q;
    assign pos_out   = pos_q;
    assign neg_out   = neg_q;
    assign evt_out   = evt_q;

`ifdef SYNC_EDGE_STICKY_EN
    logic [CH-1:0] flag_q, flag_d;

    // The OR with evt_d comes last, so a new event wins over a coincident clear.
    always_comb begin
        flag_d = (flag_q & ~evt_clr) | evt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign evt_flag = flag_q;
`endif

endmodule

// File: tb/tb_sync_edge_multi.sv
// Bench for sync_edge_multi. Three instances (FILT_LEN 1, 4 and 2) share one
// set of inputs and are compared every cycle against a sliding-window model.
// In the model, a level is accepted when the last FILT_LEN synchronised
// samples all differ from the current level.
module tb_sync_edge_multi;
    localparam int CH = 4;
    localparam int NI = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   data_in;
    logic [2*CH-1:0] edge_mode;
    logic [CH-1:0]   evt_clr;
    logic [CH-1:0]   lvl [NI];
    logic [CH-1:0]   pos [NI];
    logic [CH-1:0]   neg [NI];
    logic [CH-1:0]   evt [NI];
    logic [CH-1:0]   flg [NI];

    int tests_run    = 0;
    int tests_failed = 0;
    int fl [NI] = '{1, 4, 2};

    always #5 clk = ~clk;

    sync_edge_multi #(.CH(CH), .SYNC_STAGES(2), .FILT_LEN(1)) dut_f1 (
        .clk(clk), .rst(rst), .data_in(data_in), .edge_mode(edge_mode),
        .level_out(lvl[0]), .pos_out(pos[0]), .neg_out(neg[0]), .evt_out(evt[0])
`ifdef SYNC_EDGE_STICKY_EN
        , .evt_clr(evt_clr), .evt_flag(flg[0])
`endif
    );
    sync_edge_multi #(.CH(CH), .SYNC_STAGES(2), .FILT_LEN(4)) dut_f4 (
        .clk(clk), .rst(rst), .data_in(data_in), .edge_mode(edge_mode),
        .level_out(lvl[1]), .pos_out(pos[1]), .neg_out(neg[1]), .evt_out(evt[1])
`ifdef SYNC_EDGE_STICKY_EN
        , .evt_clr(evt_clr), .evt_flag(flg[1])
`endif
    );
    sync_edge_multi #(.CH(CH), .SYNC_STAGES(2), .FILT_LEN(2)) dut_f2 (
        .clk(clk), .rst(rst), .data_in(data_in), .edge_mode(edge_mode),
        .level_out(lvl[2]), .pos_out(pos[2]), .neg_out(neg[2]), .evt_out(evt[2])
`ifdef SYNC_EDGE_STICKY_EN
        , .evt_clr(evt_clr), .evt_flag(flg[2])
`endif
    );

    // Reference model state
    bit          m_sp  [NI][CH][2];
    bit          m_win [NI][CH][4];
    bit [CH-1:0] m_lvl [NI];
    bit [CH-1:0] m_pos [NI];
    bit [CH-1:0] m_neg [NI];
    bit [CH-1:0] m_evt [NI];
    bit [CH-1:0] m_flg [NI];

    task automatic model_tick();
        for (int m = 0; m < NI; m++) begin
            for (int c = 0; c < CH; c++) begin
                if (rst) begin
                    m_sp[m][c][0] = 0;
                    m_sp[m][c][1] = 0;
                    for (int k = 0; k < 4; k++) m_win[m][c][k] = 0;
                    m_lvl[m][c] = 0;
                    m_pos[m][c] = 0;
                    m_neg[m][c] = 0;
                    m_evt[m][c] = 0;
                    m_flg[m][c] = 0;
                end else begin
                    bit s;
                    bit all_diff;
                    s = m_sp[m][c][1];
                    for (int k = 3; k > 0; k--) m_win[m][c][k] = m_win[m][c][k-1];
                    m_win[m][c][0] = s;
                    all_diff = 1;
                    for (int k = 0; k < fl[m]; k++)
                        if (m_win[m][c][k] == m_lvl[m][c]) all_diff = 0;
                    m_pos[m][c] = all_diff & s;
                    m_neg[m][c] = all_diff & ~s;
                    if (all_diff) m_lvl[m][c] = s;
                    m_evt[m][c] = (m_pos[m][c] & edge_mode[2*c]) | (m_neg[m][c] & edge_mode[2*c+1]);
                    m_flg[m][c] = (m_flg[m][c] & ~evt_clr[c]) | m_evt[m][c];
                    m_sp[m][c][1] = m_sp[m][c][0];
                    m_sp[m][c][0] = data_in[c];
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("level[f%0d]", fl[m]), lvl[m], m_lvl[m]);
            chk($sformatf("pos[f%0d]", fl[m]), pos[m], m_pos[m]);
            chk($sformatf("neg[f%0d]", fl[m]), neg[m], m_neg[m]);
            chk($sformatf("evt[f%0d]", fl[m]), evt[m], m_evt[m]);
            chk($sformatf("pos_and_neg[f%0d]", fl[m]), pos[m] & neg[m], '0);
`ifdef SYNC_EDGE_STICKY_EN
            chk($sformatf("flag[f%0d]", fl[m]), flg[m], m_flg[m]);
`endif
        end
    endtask

    // Steps until each instance pulses pos_out[ch]; the first step is edge k (index 0).
    task automatic measure_pos(input int ch, input string tag);
        int first [NI];
        for (int m = 0; m < NI; m++) first[m] = -1;
        for (int idx = 0; idx < 12; idx++) begin
            step();
            for (int m = 0; m < NI; m++)
                if (first[m] < 0 && pos[m][ch]) first[m] = idx;
        end
        for (int m = 0; m < NI; m++)
            chk_int($sformatf("%s_latency[f%0d]", tag, fl[m]), first[m], 1 + fl[m]);
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        data_in   = '0;
        edge_mode = '0;
        evt_clr   = '0;
        step();
        step();
        for (int m = 0; m < NI; m++) chk($sformatf("reset_level[f%0d]", fl[m]), lvl[m], '0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Single-channel rise: latency SYNC_STAGES+FILT_LEN-1, other channels quiet.
        data_in = 4'b0001;
        measure_pos(0, "rise_ch0");
        data_in = 4'b0000;
        for (int i = 0; i < 8; i++) step();

        // Short glitch is dropped by FILT_LEN=4, long pulse accepted.
        data_in = 4'b0010;
        for (int i = 0; i < 3; i++) step();
        data_in = 4'b0000;
        for (int i = 0; i < 8; i++) step();
        data_in = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        data_in = 4'b0000;
        for (int i = 0; i < 8; i++) step();

        // Mode gating: ch0 none, ch1 rise, ch2 fall, ch3 both.
        edge_mode = 8'b11_10_01_00;
        data_in = 4'b1111;
        for (int i = 0; i < 8; i++) step();
        data_in = 4'b0000;
        for (int i = 0; i < 8; i++) step();

        // Reset while mid-filter with input high.
        data_in = 4'b0100;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("midrst_level[f%0d]", fl[m]), lvl[m], '0);
            chk($sformatf("midrst_pos[f%0d]", fl[m]), pos[m], '0);
        end
        rst = 1'b0;
        measure_pos(2, "after_rst");
        data_in = 4'b0000;
        for (int i = 0; i < 8; i++) step();

        // Sticky flag: set, hold, clear, clear coincident with a new event.
        edge_mode = 8'b11_11_11_11;
        data_in = 4'b0100;
        for (int i = 0; i < 8; i++) step();
        evt_clr = 4'b0100;
        step();
        evt_clr = 4'b0000;
        for (int i = 0; i < 2; i++) step();
        evt_clr = 4'b0100;
        data_in = 4'b0000;
        for (int i = 0; i < 7; i++) step();
        evt_clr = 4'b0000;
        for (int i = 0; i < 3; i++) step();

        // Alternating input every cycle: FILT_LEN=2 never accepts.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            data_in = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            step();
            pulses += $countones(pos[2] | neg[2]);
        end
        chk_int("alternate_pulses[f2]", pulses, 0);
        data_in = 4'b0000;
        for (int i = 0; i < 8; i++) step();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(3) == 0) data_in[c] = ~data_in[c];
            if ($urandom_range(15) == 0) edge_mode = 8'($urandom);
            evt_clr = 4'($urandom) & 4'($urandom);
            rst = ($urandom_range(63) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
